// File: rtl/digital_lock_fsm.sv
// digital_lock_fsm: keypad code lock with set/confirm, unlock and timed lockout; define ENTRY_TIMEOUT_EN for a partial-entry timeout
module digital_lock_fsm #(
  parameter int DIGITS = 4,
  parameter int KEY_COUNT = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCKOUT_CYCLES = 1000,
`ifdef ENTRY_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 5000,
`endif
  parameter int DIGIT_WIDTH = $clog2(KEY_COUNT),
  parameter int CODE_WIDTH = DIGITS * DIGIT_WIDTH,
  parameter int COUNTER_WIDTH = $clog2(DIGITS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [KEY_COUNT-1:0]     key,
  output logic                     locked,
  output logic                     lockout,
  output logic                     confirm_phase,
  output logic [COUNTER_WIDTH-1:0] digit_count,
  output logic                     unlock_pulse,
  output logic                     error_pulse
);
  localparam int FAIL_WIDTH = $clog2(MAX_ATTEMPTS + 1);
  localparam int TIMER_WIDTH = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {UNLOCKED_SET, SET_CONFIRM, LOCKED, LOCKOUT} state_t;
  state_t state, state_n;
  logic [KEY_COUNT-1:0] key_prev;
  logic [CODE_WIDTH-1:0] code, code_n, pending, pending_n, entry, entry_n, full_entry;
  logic [COUNTER_WIDTH-1:0] count_n;
  logic [FAIL_WIDTH-1:0] fail, fail_n, fail_inc;
  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic [DIGIT_WIDTH-1:0] digit;
  logic press, accept, final_digit, unlock_n, error_n;
`ifdef ENTRY_TIMEOUT_EN
  localparam int IDLE_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_WIDTH-1:0] idle, idle_n;
  logic timeout;
`endif
  assign press = key_prev == '0 && key != '0 && (key & (key - KEY_COUNT'(1))) == '0;
  assign accept = press && state != LOCKOUT;
  assign final_digit = accept && digit_count == COUNTER_WIDTH'(DIGITS - 1);
  assign full_entry = CODE_WIDTH'({entry, digit});
  assign fail_inc = fail == FAIL_WIDTH'(MAX_ATTEMPTS) ? fail : fail + FAIL_WIDTH'(1);
  assign locked = state == LOCKED || state == LOCKOUT;
  assign lockout = state == LOCKOUT;
  assign confirm_phase = state == SET_CONFIRM;
`ifdef ENTRY_TIMEOUT_EN
  assign timeout = state != LOCKOUT && digit_count != '0 && !accept && idle == IDLE_WIDTH'(TIMEOUT_CYCLES - 1);
`endif
  // decode the single pressed key into its digit value
  always_comb begin
    digit = '0;
    for (int i = 0; i < KEY_COUNT; i++) if (key[i]) digit = DIGIT_WIDTH'(i);
  end
  // next-state, entry accumulation and pulse generation
  always_comb begin
    state_n = state;
    code_n = code;
    pending_n = pending;
    entry_n = accept ? full_entry : entry;
    count_n = accept ? digit_count + COUNTER_WIDTH'(1) : digit_count;
    fail_n = fail;
    timer_n = timer;
    unlock_n = 1'b0;
    error_n = 1'b0;
    if (final_digit) begin
      entry_n = '0;
      count_n = '0;
    end
    case (state)
      UNLOCKED_SET: if (final_digit) begin
        pending_n = full_entry;
        state_n = SET_CONFIRM;
      end
      SET_CONFIRM: if (final_digit) begin
        if (full_entry == pending) begin
          code_n = full_entry;
          fail_n = '0;
          state_n = LOCKED;
        end else begin
          error_n = 1'b1;
          pending_n = '0;
          state_n = UNLOCKED_SET;
        end
      end
      LOCKED: if (final_digit) begin
        if (full_entry == code) begin
          unlock_n = 1'b1;
          fail_n = '0;
          state_n = UNLOCKED_SET;
        end else begin
          error_n = 1'b1;
          fail_n = fail_inc;
          if (fail_inc == FAIL_WIDTH'(MAX_ATTEMPTS)) begin
            timer_n = TIMER_WIDTH'(LOCKOUT_CYCLES - 1);
            state_n = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        entry_n = '0;
        count_n = '0;
        timer_n = timer == '0 ? '0 : timer - TIMER_WIDTH'(1);
        if (timer == '0) begin
          fail_n = '0;
          state_n = LOCKED;
        end
      end
      default: begin
        state_n = UNLOCKED_SET;
        entry_n = '0;
        count_n = '0;
        fail_n = '0;
        timer_n = '0;
        pending_n = '0;
      end
    endcase
`ifdef ENTRY_TIMEOUT_EN
    idle_n = (accept || digit_count == '0 || state == LOCKOUT) ? '0 : idle + IDLE_WIDTH'(1);
    if (timeout) begin
      entry_n = '0;
      count_n = '0;
      error_n = 1'b1;
      idle_n = '0;
      if (state == SET_CONFIRM) begin
        pending_n = '0;
        state_n = UNLOCKED_SET;
      end
    end
`endif
  end
  // state and datapath registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= UNLOCKED_SET;
      key_prev <= '0;
      code <= '0;
      pending <= '0;
      entry <= '0;
      digit_count <= '0;
      fail <= '0;
      timer <= '0;
      unlock_pulse <= 1'b0;
      error_pulse <= 1'b0;
    end else begin
      state <= state_n;
      key_prev <= key;
      code <= code_n;
      pending <= pending_n;
      entry <= entry_n;
      digit_count <= count_n;
      fail <= fail_n;
      timer <= timer_n;
      unlock_pulse <= unlock_n;
      error_pulse <= error_n;
    end
  end
`ifdef ENTRY_TIMEOUT_EN
  // idle counter for partial-entry timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idle <= '0;
    else idle <= idle_n;
  end
`endif
endmodule

// File: tb/tb_digital_lock_fsm.sv
// tb_digital_lock_fsm: directed bench with a behavioural lock model checked every cycle
module tb_digital_lock_fsm;
  localparam int DIGITS = 4;
  localparam int KEYS = 4;
  localparam int MAX = 3;
  localparam int LOCK_LEN = 1000;
  logic clock, reset;
  logic [KEYS-1:0] key;
  logic locked, lockout, confirm_phase, unlock_pulse, error_pulse;
  logic [2:0] digit_count;
  int checks = 0, errors = 0;
  int lockout_cycles = 0, unlock_seen = 0, error_seen = 0;
  int m_mode, m_entry, m_n, m_code, m_pending, m_fails, m_left;
  bit m_unlock, m_error;
  logic [KEYS-1:0] m_prev;

  digital_lock_fsm dut (
    .clock(clock), .reset(reset), .key(key), .locked(locked), .lockout(lockout),
    .confirm_phase(confirm_phase), .digit_count(digit_count),
    .unlock_pulse(unlock_pulse), .error_pulse(error_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [KEYS-1:0] k);
    int r = 0;
    for (int i = 0; i < KEYS; i++) if (k[i]) r = i;
    return r;
  endfunction

  // model: mode 0 = setting, 1 = confirming, 2 = locked, 3 = lockout; codes held as base-KEYS numbers
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_entry = 0; m_n = 0; m_code = 0; m_pending = 0;
      m_fails = 0; m_left = 0; m_unlock = 0; m_error = 0; m_prev = '0;
    end else begin
      m_unlock = 0;
      m_error = 0;
      if (m_mode == 3) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 2;
          m_fails = 0;
        end
      end else if (m_prev == '0 && $countones(key) == 1) begin
        m_entry = m_entry * KEYS + key_index(key);
        m_n++;
        if (m_n == DIGITS) begin
          if (m_mode == 0) begin
            m_pending = m_entry;
            m_mode = 1;
          end else if (m_mode == 1) begin
            if (m_entry == m_pending) begin
              m_code = m_entry;
              m_fails = 0;
              m_mode = 2;
            end else begin
              m_error = 1;
              m_mode = 0;
            end
          end else if (m_entry == m_code) begin
            m_unlock = 1;
            m_fails = 0;
            m_mode = 0;
          end else begin
            m_error = 1;
            if (m_fails < MAX) m_fails++;
            if (m_fails == MAX) begin
              m_mode = 3;
              m_left = LOCK_LEN;
            end
          end
          m_entry = 0;
          m_n = 0;
        end
      end
      m_prev = key;
    end
  end

  // compare DUT against model just after every active edge
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      check("locked", locked, int'(m_mode >= 2));
      check("lockout", lockout, int'(m_mode == 3));
      check("confirm_phase", confirm_phase, int'(m_mode == 1));
      check("digit_count", digit_count, m_n);
      check("unlock_pulse", unlock_pulse, m_unlock);
      check("error_pulse", error_pulse, m_error);
      if (lockout) lockout_cycles++;
      unlock_seen += int'(unlock_pulse);
      error_seen += int'(error_pulse);
    end
  end

  task automatic press(input int d);
    @(negedge clock);
    key = KEYS'(1 << d);
    @(negedge clock);
    key = '0;
  endtask

  task automatic enter(input int a, input int b, input int c, input int e);
    press(a); press(b); press(c); press(e);
  endtask

  initial begin
    clock = 0;
    reset = 1;
    key = '0;
    repeat (2) @(negedge clock);
    check("reset_locked", locked, 0);
    check("reset_lockout", lockout, 0);
    check("reset_confirm", confirm_phase, 0);
    check("reset_digits", digit_count, 0);
    reset = 0;
    enter(1, 2, 3, 0);
    check("set_confirm_phase", confirm_phase, 1);
    enter(1, 2, 3, 0);
    check("set_locked", locked, 1);
    check("set_no_error", error_seen, 0);
    enter(1, 2, 3, 0);
    check("unlock_locked", locked, 0);
    check("unlock_pulses", unlock_seen, 1);
    check("unlock_digits", digit_count, 0);
    enter(1, 2, 3, 0);
    enter(1, 2, 3, 1);
    check("mismatch_errors", error_seen, 1);
    check("mismatch_confirm", confirm_phase, 0);
    check("mismatch_locked", locked, 0);
    enter(1, 2, 3, 0);
    enter(1, 2, 3, 0);
    check("relock_locked", locked, 1);
    repeat (3) enter(0, 0, 0, 0);
    check("lockout_errors", error_seen, 4);
    check("lockout_on", lockout, 1);
    press(2);
    press(1);
    check("lockout_digits", digit_count, 0);
    for (int i = 0; i < 1100 && lockout; i++) @(negedge clock);
    check("lockout_end", lockout, 0);
    check("lockout_len", lockout_cycles, LOCK_LEN);
    check("after_lockout_locked", locked, 1);
    enter(1, 2, 3, 0);
    check("post_lockout_unlock", locked, 0);
    check("post_lockout_pulses", unlock_seen, 2);
    @(negedge clock);
    key = 4'b0110;
    @(negedge clock);
    key = '0;
    check("multi_key_ignored", digit_count, 0);
    @(negedge clock);
    key = 4'b0100;
    repeat (19) @(negedge clock);
    key = '0;
    @(negedge clock);
    check("held_key_one_digit", digit_count, 1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    enter(1, 2, 3, 0);
    enter(1, 2, 3, 0);
    press(1);
    press(2);
    check("mid_entry_digits", digit_count, 2);
    check("mid_entry_locked", locked, 1);
    #2 reset = 1;
    #1;
    check("async_locked", locked, 0);
    check("async_digits", digit_count, 0);
    #1 reset = 0;
    enter(0, 0, 0, 0);
    check("post_reset_set", confirm_phase, 1);
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
